// File: rtl/inv_broadcast_arbiter_pkg.sv
// Shared types for the instruction-invalidation broadcast path.
package inv_broadcast_arbiter_pkg;

  localparam int INV_ADDR_W = 30;

  typedef logic [INV_ADDR_W-1:0] inv_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2,
    WAIT  = 2'd3
  } inv_fence_state_t;

endpackage

// File: rtl/inv_broadcast_arbiter_rr.sv
// Round-robin single-grant arbiter. The search starts at the pointer, and the
// pointer moves past the winner whenever a grant is issued.
module inv_rr_arbiter #(
  parameter int NUM_SOURCES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_SOURCES-1:0] request,
  output logic [NUM_SOURCES-1:0] grant
);

  localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [PTR_W-1:0] ptr_reg;
  int               sel_idx;
  int               cand_idx;

  // Walk from the farthest candidate back to the pointer so the nearest requester wins.
  always_comb begin
    grant    = '0;
    sel_idx  = 0;
    cand_idx = 0;
    if (enable) begin
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
        cand_idx = (int'(ptr_reg) + i) % NUM_SOURCES;
        if (request[cand_idx]) begin
          grant          = '0;
          grant[cand_idx] = 1'b1;
          sel_idx        = cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (|grant) begin
      ptr_reg <= PTR_W'((sel_idx + 1) % NUM_SOURCES);
    end
  end

endmodule

// File: rtl/inv_broadcast_arbiter.sv
// Queues invalidation requests from several sources and broadcasts each entry
// to all sinks, retiring it once every sink has accepted; includes a drain fence.
module inv_broadcast_arbiter
  import inv_broadcast_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int NUM_SINKS   = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_SOURCES-1:0][INV_ADDR_W-1:0] src_inv_addr,
  input  logic [NUM_SOURCES-1:0]                 src_inv_valid,
  output logic [NUM_SOURCES-1:0]                 src_inv_ready,
  output logic [INV_ADDR_W-1:0]                  sink_inv_addr,
  output logic [NUM_SINKS-1:0]                   sink_inv_valid,
  input  logic [NUM_SINKS-1:0]                   sink_inv_ready,
  input  logic [NUM_SINKS-1:0]                   sink_inv_outstanding,
  output logic                                   inv_completed,
  output logic                                   inv_outstanding,
  input  logic                                   fence_req,
  output logic                                   fence_ack
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  inv_addr_t        fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [NUM_SINKS-1:0] accepted_mask_reg;
  logic [NUM_SINKS-1:0] accepted_mask_next;
  logic             inv_completed_reg;
  logic             ready_en_reg;
  inv_fence_state_t fence_state_reg;

  logic      fifo_empty;
  logic      fifo_full;
  logic      src_enable;
  logic      push;
  logic      pop;
  inv_addr_t push_addr;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(QUEUE_DEPTH));

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign src_enable = ready_en_reg & ~rst & ~fifo_full & (fence_state_reg == IDLE);

  inv_rr_arbiter #(
    .NUM_SOURCES(NUM_SOURCES)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .enable (src_enable),
    .request(src_inv_valid),
    .grant  (src_inv_ready)
  );

  assign push = |src_inv_ready;

  always_comb begin
    push_addr = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (src_inv_ready[i]) push_addr = src_inv_addr[i];
    end
  end

  assign sink_inv_addr      = fifo_mem[rd_ptr_reg];
  assign sink_inv_valid     = (rst | fifo_empty) ? '0 : ~accepted_mask_reg;
  assign accepted_mask_next = accepted_mask_reg | (sink_inv_valid & sink_inv_ready);
  assign pop                = ~fifo_empty & (&accepted_mask_next);

  assign inv_completed   = inv_completed_reg & ~rst;
  assign fence_ack       = (fence_state_reg == ACK) & ~rst;
  assign inv_outstanding = ~fifo_empty | (|sink_inv_outstanding) | inv_completed_reg;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      count_reg         <= '0;
      accepted_mask_reg <= '0;
      inv_completed_reg <= 1'b0;
      ready_en_reg      <= 1'b0;
    end else begin
      ready_en_reg      <= 1'b1;
      inv_completed_reg <= pop;
      accepted_mask_reg <= pop ? '0 : accepted_mask_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // A falling request during the drain abandons the fence without acknowledging.
  always_ff @(posedge clk) begin
    if (rst) begin
      fence_state_reg <= IDLE;
    end else begin
      unique case (fence_state_reg)
        IDLE:  if (fence_req) fence_state_reg <= DRAIN;
        DRAIN: begin
          if (!fence_req)
            fence_state_reg <= IDLE;
          else if (fifo_empty && !(|sink_inv_outstanding))
            fence_state_reg <= ACK;
        end
        ACK:   fence_state_reg <= fence_req ? WAIT : IDLE;
        WAIT:  if (!fence_req) fence_state_reg <= IDLE;
        default: fence_state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/inv_broadcast_arbiter.md
Name: inv_broadcast_arbiter

Overview:
- Collects word-addressed instruction-invalidation requests from several sources (store paths, debug and similar).
- Buffers them in order and broadcasts each one to every invalidation sink (I-cache, fetch buffer and similar).
- Retires an entry only once every sink has accepted it.
- Sits between the source-side and sink-side invalidation interfaces, and provides a fence so software can wait for global invalidation completion.

Parameters:
- NUM_SOURCES, 2, number of requesting sources (>=1).
- NUM_SINKS, 2, number of sinks that must each accept every invalidation (>=1).
- QUEUE_DEPTH, 4, entries in the internal request FIFO (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- src_inv_addr  in  NUM_SOURCES x 30  word address [31:2] per source.
- src_inv_valid  in  NUM_SOURCES  request valid per source.
- src_inv_ready  out  NUM_SOURCES  request accepted this cycle (one-hot or zero).
- sink_inv_addr  out  30  address of the head entry, shared by all sinks.
- sink_inv_valid  out  NUM_SINKS  per-sink valid.
- sink_inv_ready  in  NUM_SINKS  per-sink accept.
- sink_inv_outstanding  in  NUM_SINKS  sink still processing an accepted invalidation.
- inv_completed  out  1  one-cycle pulse per fully broadcast entry.
- inv_outstanding  out  1  any work queued, broadcasting, or outstanding in any sink.
- fence_req  in  1  level; request drain.
- fence_ack  out  1  one-cycle pulse when drain is complete.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset clears FIFO, accept mask, round-robin pointer (0), fence state and all registered outputs.
  - src_inv_ready=0, sink_inv_valid=0, inv_completed=0, fence_ack=0 during reset and in the cycle it is released.
- Source side: handshake is valid&ready; at most one accept per cycle.
  - Grant is round-robin starting from the rr pointer.
  - After a grant to source k, the pointer becomes k+1 mod NUM_SOURCES. The pointer is unchanged when nothing is granted.
- src_inv_ready is 0 for all sources when the FIFO is full (registered count == QUEUE_DEPTH) or the fence FSM is not IDLE.
  - A pop in the same cycle does not free a slot for a push.
- Ready may depend on valid (needed for the grant). Valid must not depend on ready.
- FIFO: no bypass. An entry accepted at cycle t is at the head no earlier than t+1, so sink_inv_valid rises no earlier than t+1.
- Broadcast: a per-sink accepted_mask register (reset 0).
  - sink_inv_valid[i] = FIFO non-empty & ~accepted_mask[i]. sink_inv_addr = head address.
  - Each cycle: accepted_mask |= sink_inv_valid & sink_inv_ready.
  - When (accepted_mask | (sink_inv_valid & sink_inv_ready)) is all ones: pop the head, clear the mask to 0, and pulse inv_completed in the next cycle (registered).
- Sinks may accept in different cycles; a sink never sees the same entry twice.
  - With all sinks ready and consecutive entries queued: one entry per cycle, back-to-back.
- inv_outstanding = FIFO non-empty | (|sink_inv_outstanding) | inv_completed pending.
- Fence FSM:
  - IDLE -> DRAIN when fence_req=1.
  - DRAIN -> ACK when FIFO empty & all sink_inv_outstanding=0.
  - ACK: fence_ack=1 for one cycle; -> WAIT if fence_req is still 1, else -> IDLE.
  - WAIT -> IDLE when fence_req=0.
  - Sources are blocked in DRAIN, ACK and WAIT.
  - fence_req falling in DRAIN returns the FSM to IDLE with no ack.
- Count arithmetic: count width $clog2(QUEUE_DEPTH)+1. Read/write pointers wrap modulo QUEUE_DEPTH.

Decomposition:
- cva5_types: typedef inv_addr_t (logic [29:0]); enum inv_fence_state_t {IDLE, DRAIN, ACK, WAIT}.
- FIFO: reuse the existing codebase FIFO through fifo_interface with DATA_WIDTH=30.
- One new sub-module, inv_rr_arbiter: NUM_SOURCES-wide round-robin grant with pointer update.

Test Plan:
- 1 source, 2 sinks both ready, push 0x0000_1000>>2 at cycle 0 -> sink_inv_valid=2'b11 at cycle 1, pop at 1, inv_completed=1 at cycle 2, queue empty.
- Sink0 ready at cycle 1, sink1 ready at cycle 4 -> sink_inv_valid=2'b10 from cycle 2 to 4; single pop at 4; inv_completed at 5; sink0 sees the entry exactly once.
- Both sources valid continuously, QUEUE_DEPTH=4, sinks stalled -> grants alternate 0,1,0,1; src_inv_ready=0 once count=4; a push is refused in the same cycle as the first pop; FIFO order preserved at sinks.
- 3 entries queued, sinks always ready -> inv_completed high for 3 consecutive cycles, addresses in order.
- fence_req raised with 2 entries queued and sink_inv_outstanding[1]=1 until cycle 10 -> sources blocked, fence_ack single pulse at cycle 11; fence_req held -> WAIT; drop -> IDLE, sources accepted again.
- rst asserted mid-broadcast with mask=2'b01 -> next cycle all outputs 0, queue empty, rr pointer 0; new request is broadcast to both sinks.
